serial_adder: RTL

Parametrised multi-cycle adder/subtractor. It adds or subtracts two WIDTH-bit operands DIGIT bits per clock, using a registered carry between digits, behind a start/done handshake. It succeeds the single-bit gate-level full adder and reuses it as the per-bit cell of a DIGIT-wide ripple slice. It trades latency for area in arithmetic datapaths on the Cu board.

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/adder_slice.sv | 31 +++
 rtl/full_adder.sv | 16 +
 rtl/serial_adder.sv | 106 ++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding and
// elaboration-time helpers for parameter legality and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic bit params_legal(input int width, input int digit);
    return (digit >= 1) && (width >= digit) && ((width % digit) == 0);
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// DIGIT-wide ripple-carry slice built from full_adder cells; purely combinational.
module adder_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // c_msb is the carry into the top bit; XOR with co gives signed overflow
  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// Gate-level single-bit full adder, used as the per-bit cell of adder_slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per
// clock through one ripple slice with a registered carry, start/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  if (!params_legal(WIDTH, DIGIT)) begin : g_illegal
    $error("serial_adder: DIGIT must be >= 1 and divide WIDTH");
  end

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last, accept;
  logic [DIGIT-1:0] slice_s;
  logic             slice_co, slice_cmsb;

  // Drop the consumed low digit and insert the new result digit at the top.
  function automatic logic [WIDTH-1:0] shift_in(input logic [DIGIT-1:0] d,
                                                input logic [WIDTH-1:0] r);
    return WIDTH'({d, r} >> DIGIT);
  endfunction

  adder_slice #(.DIGIT(DIGIT)) u_slice (
    .a     (a_sh[DIGIT-1:0]),
    .b     (b_sh[DIGIT-1:0]),
    .ci    (carry),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_cmsb)
  );

  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last) state_next = S_DONE;
      S_DONE:  state_next = start ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == S_RUN);
    done   = (state == S_DONE);
    accept = start && ((state == S_IDLE) || (state == S_DONE));
  end

  // a_sh doubles as the result shift register: each consumed A digit is
  // replaced at the top by the matching result digit. Outputs are loaded on
  // the final digit so they are already valid during the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= sub ? ~cin : cin;
      cnt   <= '0;
    end else if (busy) begin
      a_sh  <= shift_in(slice_s, a_sh);
      b_sh  <= b_sh >> DIGIT;
      carry <= slice_co;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum  <= shift_in(slice_s, a_sh);
        cout <= slice_co;
        ovf  <= slice_cmsb ^ slice_co;
      end
    end
  end

endmodule
